// File: rtl/sushi_belt_ctrl.sv
// Belt scheduler: round-robin loading of a rotating ring of plate slots by four
// chefs, fixed-rate rotation and a single pickup station opposite the load slot.
module sushi_belt_ctrl #(
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DISH_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [3:0]                req,
  input  logic [4*DISH_W-1:0]       dish_in,
  input  logic                      take,
  output logic [3:0]                gnt,
  output logic                      pick_valid,
  output logic [DISH_W-1:0]         pick_dish,
  output logic [$clog2(SLOTS)-1:0]  head,
  output logic [$clog2(SLOTS):0]    count,
  output logic                      step
);

  localparam int unsigned PTR_W  = $clog2(SLOTS);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HALF   = SLOTS / 2;

  logic [SLOTS-1:0]  valid_q, valid_d;
  logic [DISH_W-1:0] dish_q [SLOTS];
  logic [DISH_W-1:0] dish_d [SLOTS];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              step_q, step_d;

  logic [3:0]        gnt_c;
  logic [1:0]        scan_idx;
  logic              found;
  logic [1:0]        gidx;
  logic [DISH_W-1:0] load_dish;
  logic [PTR_W-1:0]  pick_idx;
  logic              load;
  logic              take_ok;

  assign pick_idx = head_q + PTR_W'(HALF);
  assign load     = |gnt_c;
  assign take_ok  = en && take && valid_q[pick_idx];

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    gnt_c    = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (!rst && en && !valid_q[head_q]) begin
      for (int k = 1; k <= 4; k++) begin
        scan_idx = rr_q + 2'(k);
        if (!found && req[scan_idx]) begin
          gnt_c[scan_idx] = 1'b1;
          found           = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_dish = '0;
    gidx      = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_c[i]) begin
        load_dish = dish_in[i*DISH_W +: DISH_W];
        gidx      = 2'(i);
      end
    end
  end

  // Next-state: load and take always hit distinct slots, both use pre-step head.
  always_comb begin
    valid_d = valid_q;
    dish_d  = dish_q;
    head_d  = head_q;
    tick_d  = tick_q;
    rr_d    = rr_q;
    count_d = count_q;
    step_d  = step_q;
    if (en) begin
      if (tick_q == TICK_W'(TICK_DIV - 1)) begin
        tick_d = '0;
        head_d = head_q + PTR_W'(1);
        step_d = 1'b1;
      end else begin
        tick_d = tick_q + TICK_W'(1);
        step_d = 1'b0;
      end
      if (take_ok) begin
        valid_d[pick_idx] = 1'b0;
        dish_d[pick_idx]  = '0;
      end
      if (load) begin
        valid_d[head_q] = 1'b1;
        dish_d[head_q]  = load_dish;
        rr_d            = gidx;
      end
      case ({load, take_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dish_q  <= '{default: '0};
      head_q  <= '0;
      tick_q  <= '0;
      rr_q    <= 2'd3;
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dish_q  <= dish_d;
      head_q  <= head_d;
      tick_q  <= tick_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign gnt        = gnt_c;
  assign pick_valid = valid_q[pick_idx];
  assign pick_dish  = valid_q[pick_idx] ? dish_q[pick_idx] : '0;
  assign head       = head_q;
  assign count      = count_q;
  assign step       = step_q;

endmodule
